// File: rtl/fsm_ctrl_pkg.sv
// fsm_ctrl_pkg: shared types and helpers for the FIFO control state machine.
// One-hot state encoding and the hold-counter width function.
package fsm_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    localparam int NUM_STATES = 5;

    // Width able to hold values 0..hold so the counter can saturate at hold.
    function automatic int cnt_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/fsm_control_param_idle_hold_counter.sv
// idle_hold_counter: counts consecutive all-empty cycles while the control FSM
// is ACTIVE. done flags the cycle on which the FSM may fall back to IDLE.
module idle_hold_counter
    import fsm_ctrl_pkg::*;
#(
    parameter int IDLE_HOLD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic all_empty,
    output logic done
);

    localparam int CW = cnt_width(IDLE_HOLD);
    localparam logic [CW-1:0] TERM = CW'(IDLE_HOLD - 1);
    localparam logic [CW-1:0] MAX  = CW'(IDLE_HOLD);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With IDLE_HOLD=1 the terminal value is 0, so one all-empty cycle suffices.
    assign done = all_empty && (cnt_q == TERM);

    // Next count: a non-empty cycle or an external clear restarts, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !all_empty) begin
            cnt_d = '0;
        end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_control_param.sv
// fsm_control_param: supervises NUM_FIFO FIFOs, latches their thresholds during
// INIT and reports active / idle / error status.
// Optional feature: define FSM_ERR_CAPTURE_EN to build the per-FIFO error
// capture register behind error_fifo; otherwise error_fifo is tied to 0.
// Handshake: none; init, FIFO_error and FIFO_empty are level inputs sampled on
// every rising edge, and all status outputs are decoded from the state register.
module fsm_control_param
    import fsm_ctrl_pkg::*;
#(
    parameter int NUM_FIFO  = 5,
    parameter int TH_W      = 4,
    parameter int IDLE_HOLD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [NUM_FIFO*TH_W-1:0] umbrales_in,
    input  logic [NUM_FIFO-1:0]      FIFO_error,
    input  logic [NUM_FIFO-1:0]      FIFO_empty,
    output logic [NUM_FIFO*TH_W-1:0] umbrales_I,
    output logic                     active,
    output logic                     idle,
    output logic                     error,
    output logic [NUM_FIFO-1:0]      error_fifo,
    output logic [4:0]               state_dbg
);

    state_t                     state_q;
    state_t                     state_d;
    logic [NUM_FIFO*TH_W-1:0]   umbrales_q;
    logic                       any_err;
    logic                       all_empty;
    logic                       hold_clear;
    logic                       hold_done;

    assign any_err   = |FIFO_error;
    assign all_empty = &FIFO_empty;

    // Counter only runs across cycles that start and stay in ACTIVE.
    assign hold_clear = (state_q != ST_ACTIVE) || (state_d != ST_ACTIVE);

    idle_hold_counter #(
        .IDLE_HOLD (IDLE_HOLD)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .clear     (hold_clear),
        .all_empty (all_empty),
        .done      (hold_done)
    );

    // Next-state logic; priority is error > init > empty logic, ERROR is sticky.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT: begin
                if (any_err)      state_d = ST_ERROR;
                else if (!init)   state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_err)         state_d = ST_ERROR;
                else if (init)       state_d = ST_INIT;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)        state_d = ST_ERROR;
                else if (init)      state_d = ST_INIT;
                else if (hold_done) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    // State and threshold registers; thresholds track the input only in INIT without error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            umbrales_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && !any_err) begin
                umbrales_q <= umbrales_in;
            end
        end
    end

`ifdef FSM_ERR_CAPTURE_EN
    logic [NUM_FIFO-1:0] err_cap_q;

    // Accumulate error flags on the edge entering ERROR and every edge while there.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cap_q <= '0;
        end else if (state_d == ST_ERROR) begin
            err_cap_q <= err_cap_q | FIFO_error;
        end
    end

    assign error_fifo = err_cap_q;
`else
    assign error_fifo = '0;
`endif

    assign umbrales_I = umbrales_q;
    assign active     = (state_q == ST_ACTIVE);
    assign idle       = (state_q == ST_IDLE);
    assign error      = (state_q == ST_ERROR);
    assign state_dbg  = state_q;

endmodule
